// File: rtl/failval_rom_arbiter.sv
// Round-robin arbiter sharing the single failVal_rom read port between N_REQ requesters.
// A {valid, owner} tag pipeline matched to ROM_LAT routes each returned word to its requester.
module failval_rom_arbiter #(
    parameter int N_REQ   = 2,
    parameter int W_DATA  = 13,
    parameter int W_ADDR  = 12,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*W_ADDR-1:0]   req_addr,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [W_DATA-1:0]         rsp_data,
    output logic                      rom_en,
    output logic [W_ADDR-1:0]         rom_addr,
    input  logic [W_DATA-1:0]         rom_data
);

    localparam int W_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshake: requester i transfers on a clock edge where req_valid[i] & req_ready[i].
    // Requesters hold valid/addr stable until that edge; responses have no backpressure.

    logic [W_PTR-1:0] rr_ptr_q, rr_ptr_d;
    logic [W_PTR-1:0] gnt_idx;
    logic             gnt_any;
    logic             hs;
    logic [N_REQ-1:0] gnt_oh;

    logic [ROM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [N_REQ-1:0]   tag_own_q [ROM_LAT];
    logic [N_REQ-1:0]   tag_own_d [ROM_LAT];

    // Search starts at rr_ptr and wraps, so the most recently served requester is tried last.
    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = W_PTR'(idx);
            end
        end
    end

    always_comb begin
        hs     = gnt_any & ~rst;
        gnt_oh = '0;
        if (hs) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = W_PTR'((int'(gnt_idx) + 1) % N_REQ);
        end
    end

    always_comb begin
        tag_vld_d    = '0;
        tag_own_d[0] = gnt_oh;
        tag_vld_d[0] = hs;
        for (int s = 1; s < ROM_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_own_d[s] = tag_own_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_own_q[s] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            tag_vld_q <= tag_vld_d;
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_own_q[s] <= tag_own_d[s];
            end
        end
    end

    always_comb begin
        req_ready = gnt_oh;
        rom_en    = hs;
        rom_addr  = '0;
        if (hs) begin
            rom_addr = req_addr[int'(gnt_idx)*W_ADDR +: W_ADDR];
        end
        rsp_valid = tag_own_q[ROM_LAT-1] & {N_REQ{tag_vld_q[ROM_LAT-1]}};
        rsp_data  = rom_data;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_ready));
            assert ($onehot0(rsp_valid));
            assert ((req_ready & ~req_valid) == '0);
        end
    end

endmodule

// File: tb/tb_failval_rom_arbiter.sv
// Bench for failval_rom_arbiter: ROM_LAT=1 and ROM_LAT=2 instances, a behavioural ROM,
// a round-robin reference model and per-instance expected-response queues.
module tb_failval_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic [1:0]  v1 = '0, v2 = '0;
    logic [23:0] addr1 = '0, addr2 = '0;
    logic [1:0]  rdy1, rdy2, rv1, rv2;
    logic [12:0] rd1, rd2, romd1, romd2;
    logic        en1, en2;
    logic [11:0] ra1, ra2;

    // entry: {due_cycle[15:0], owner[1:0], data[12:0]}
    logic [30:0] exp_q1[$];
    logic [30:0] exp_q2[$];
    int          rr_m1 = 0, rr_m2 = 0;

    failval_rom_arbiter #(.N_REQ(2), .W_DATA(13), .W_ADDR(12), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_addr(addr1), .req_ready(rdy1),
        .rsp_valid(rv1), .rsp_data(rd1), .rom_en(en1), .rom_addr(ra1), .rom_data(romd1)
    );

    failval_rom_arbiter #(.N_REQ(2), .W_DATA(13), .W_ADDR(12), .ROM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_addr(addr2), .req_ready(rdy2),
        .rsp_valid(rv2), .rsp_data(rd2), .rom_en(en2), .rom_addr(ra2), .rom_data(romd2)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural ROM ----------------
    function automatic logic [12:0] rom_val(input logic [11:0] a);
        logic [12:0] t;
        case (a)
            12'h000: t = 13'h0216;
            12'h001: t = 13'h1E23;
            12'h002: t = 13'h1E7E;
            12'h003: t = 13'h1F21;
            12'h005: t = 13'h008E;
            default: t = ({1'b0, a} * 13'd7) ^ 13'h0A5A;
        endcase
        return t;
    endfunction

    logic [12:0] rp1;
    logic [12:0] rp2a, rp2b;
    always @(posedge clk) begin
        rp1  <= en1 ? rom_val(ra1) : 13'h0;
        rp2a <= en2 ? rom_val(ra2) : 13'h0;
        rp2b <= rp2a;
    end
    assign romd1 = rp1;
    assign romd2 = rp2b;

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [30:0] h;
        if (exp_q1.size() > 0 && exp_q1[0][30:15] == cyc[15:0]) begin
            h = exp_q1.pop_front();
            n_assert++;
            if (rv1 !== h[14:13] || rd1 !== h[12:0]) begin
                n_fail++;
                $display("FAIL rsp_lat1 cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                         cyc, rv1, rd1, h[14:13], h[12:0]);
            end
        end else begin
            n_assert++;
            if (rv1 !== 2'b00) begin
                n_fail++;
                $display("FAIL rsp_lat1_idle cyc=%0d: got valid=%b, want 00", cyc, rv1);
            end
        end
    end

    always @(negedge clk) begin
        logic [30:0] h;
        if (exp_q2.size() > 0 && exp_q2[0][30:15] == cyc[15:0]) begin
            h = exp_q2.pop_front();
            n_assert++;
            if (rv2 !== h[14:13] || rd2 !== h[12:0]) begin
                n_fail++;
                $display("FAIL rsp_lat2 cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                         cyc, rv2, rd2, h[14:13], h[12:0]);
            end
        end else begin
            n_assert++;
            if (rv2 !== 2'b00) begin
                n_fail++;
                $display("FAIL rsp_lat2_idle cyc=%0d: got valid=%b, want 00", cyc, rv2);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic int model_grant(input logic [1:0] v, input int ptr);
        int g;
        g = -1;
        for (int k = 0; k < 2; k++) begin
            if (g < 0 && v[(ptr + k) % 2]) g = (ptr + k) % 2;
        end
        return g;
    endfunction

    // One clock of stimulus on instance inst; pushes the model's expected response.
    task automatic drive_cycle(input int inst, input logic [1:0] v, input logic [11:0] a0,
                               input logic [11:0] a1, output logic [1:0] rdy,
                               output logic en, output int g);
        logic [12:0] d;
        logic [1:0]  oh;
        if (inst == 1) begin
            v1 = v; addr1 = {a1, a0};
        end else begin
            v2 = v; addr2 = {a1, a0};
        end
        @(negedge clk);
        rdy = (inst == 1) ? rdy1 : rdy2;
        en  = (inst == 1) ? en1 : en2;
        g   = model_grant(v, (inst == 1) ? rr_m1 : rr_m2);
        if (g >= 0) begin
            d  = rom_val((g == 0) ? a0 : a1);
            oh = (g == 0) ? 2'b01 : 2'b10;
            if (inst == 1) exp_q1.push_back({16'(cyc + 1), oh, d});
            else           exp_q2.push_back({16'(cyc + 2), oh, d});
        end
        @(posedge clk);
        if (g >= 0) begin
            if (inst == 1) rr_m1 = (g + 1) % 2;
            else           rr_m2 = (g + 1) % 2;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        v1 = '0; v2 = '0;
        exp_q1.delete(); exp_q2.delete();
        rr_m1 = 0; rr_m2 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int inst, input int n);
        logic [1:0] r;
        logic       e;
        int         g;
        for (int i = 0; i < n; i++) drive_cycle(inst, 2'b00, 12'h0, 12'h0, r, e, g);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        v1 = 2'b11; v2 = 2'b11; addr1 = {12'h005, 12'h001}; addr2 = addr1;
        @(negedge clk);
        n_assert++;
        if (rdy1 !== 2'b00 || rdy2 !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b/%b, want 00/00", rdy1, rdy2);
        end
        n_assert++;
        if (en1 !== 1'b0 || en2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_rom_en: got %b/%b, want 0/0", en1, en2);
        end
        v1 = '0; v2 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] r; logic e; int g;
        drive_cycle(1, 2'b01, 12'h000, 12'h000, r, e, g);
        n_assert++;
        if (r !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b, want 01", r); end
        n_assert++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL single_rom_en: got %b, want 1", e); end
        idle(1, 2);
    endtask

    task automatic test_back_to_back();
        logic [1:0] r; logic e; int g;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 2'b01, 12'(i), 12'h000, r, e, g);
            n_assert++;
            if (r !== 2'b01) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got %b, want 01", i, r);
            end
        end
        idle(1, 2);
    endtask

    task automatic test_contention();
        logic [1:0] r; logic e; int g;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive_cycle(1, 2'b11, 12'h001, 12'h005, r, e, g);
            n_assert++;
            if (r !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL contention_ready[%0d]: got %b, want %b", k, r,
                                   (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic test_idle_ptr();
        logic [1:0] r; logic e; int g;
        drive_cycle(1, 2'b10, 12'h000, 12'h007, r, e, g);
        n_assert++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL idle_r1_ready: got %b, want 10", r); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 2'b00, 12'h000, 12'h000, r, e, g);
            n_assert++;
            if (r !== 2'b00 || e !== 1'b0) begin
                n_fail++; $display("FAIL idle_quiet[%0d]: got ready=%b en=%b, want 00/0", i, r, e);
            end
        end
        drive_cycle(1, 2'b11, 12'h008, 12'h009, r, e, g);
        n_assert++;
        if (r !== 2'b01) begin n_fail++; $display("FAIL idle_resume_ready: got %b, want 01", r); end
        idle(1, 2);
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic e; int g;
        v1 = 2'b01; addr1 = {12'h000, 12'h002};
        @(negedge clk);
        n_assert++;
        if (rdy1 !== 2'b01) begin n_fail++; $display("FAIL rstmid_pre_ready: got %b, want 01", rdy1); end
        #1;
        rst = 1'b1;
        exp_q1.delete();
        rr_m1 = 0;
        v1 = 2'b11; addr1 = {12'h004, 12'h003};
        @(negedge clk);
        n_assert++;
        if (rdy1 !== 2'b00 || en1 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_held: got ready=%b en=%b, want 00/0", rdy1, en1);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_cycle(1, 2'b11, 12'h003, 12'h004, r, e, g);
        n_assert++;
        if (r !== 2'b01) begin n_fail++; $display("FAIL rstmid_after_ready: got %b, want 01", r); end
        idle(1, 2);
    endtask

    task automatic test_random();
        logic [1:0]  r; logic e; int g;
        logic [1:0]  pend;
        logic [11:0] a [2];
        pend = '0; a[0] = '0; a[1] = '0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    a[i] = 12'($urandom_range(4095, 0));
                end
            end
            drive_cycle(1, pend, a[0], a[1], r, e, g);
            n_assert++;
            if (r !== ((g < 0) ? 2'b00 : (g == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL random_ready[%0d]: got %b, model grant %0d", c, r, g);
            end
            if (g >= 0) pend[g] = 1'b0;
        end
        idle(1, 2);
    endtask

    task automatic test_lat2();
        logic [1:0]  r; logic e; int g;
        logic [11:0] a [2];
        apply_reset();
        a[0] = 12'h001; a[1] = 12'h005;
        for (int k = 0; k < 12; k++) begin
            drive_cycle(2, 2'b11, a[0], a[1], r, e, g);
            n_assert++;
            if (r !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL lat2_ready[%0d]: got %b, want %b", k, r,
                                   (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (g >= 0) a[g] = 12'($urandom_range(4095, 0));
        end
        idle(2, 4);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        idle(1, 2);
        test_idle_ptr();
        test_reset_mid();
        test_random();
        test_lat2();
        n_assert++;
        if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d responses outstanding, want 0/0",
                     exp_q1.size(), exp_q2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
